ram_arbiter: RTL

- Two-requester round-robin arbiter that shares one single_port_ram instance (registered read, 1-cycle latency, dout tri-stated when not reading) between requester 0 and requester 1.
- Drives the RAM's en/we/addr/din each cycle and routes the returned read data back to the requester that issued the read.
- Supports a bounded lock so one requester can perform an atomic read-modify-write sequence.

---
 rtl/ram_arb_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 27 ++
 rtl/single_port_ram.sv | 43 ++++
 rtl/ram_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared definitions for the two-requester RAM arbiter: arbiter
//            state encodings, requester identifiers and small helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  // Arbiter state encoding
  localparam logic [1:0] ARB   = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  // Requester identifiers
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Identifier of the requester that is not 'id'
  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

  // Locked state that belongs to requester 'id'
  function automatic logic [1:0] lock_state_of(input logic id);
    return (id == REQ1) ? LOCK1 : LOCK0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin grant logic. A lone request is granted
//            directly; on contention the pointer picks the winner.
// Ports    : req[1:0] - request vector (bit N = requester N)
//            ptr      - favoured requester when both request
//            gnt[1:0] - one-hot grant (all zero when nothing requests)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = (ptr == REQ1) ? 2'b10 : 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: rtl/single_port_ram.sv
`default_nettype none
// ============================================================================
// Module   : single_port_ram
// Purpose  : Single-port RAM with registered read (1-cycle latency). dout is
//            released to high impedance in every cycle that is not returning
//            read data.
// Ports    : clk              - clock
//            en, we           - access enable, 1 = write / 0 = read
//            addr, din        - access address and write data
//            dout             - read data (valid the cycle after a read)
// Revision : 1.0 - initial release
// ============================================================================
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rd_q;

  always_ff @(posedge clk) begin
    rd_q <= en & ~we;
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout_q <= mem[addr];
      end
    end
  end

  assign dout = rd_q ? dout_q : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Shares one single-port RAM between two requesters with
//            round-robin arbitration, per-requester read data return and a
//            bounded lock for atomic read-modify-write sequences.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            reqN/weN/lockN            - request, write enable, hold ownership
//            addrN/dinN                - access address and write data
//            gntN                      - combinational accept of the access
//            rvalidN/rdataN            - read data return (1 cycle after read)
//            lock_timeout              - 1-cycle pulse on forced lock release
//            ram_en/ram_we/ram_addr/ram_din/ram_dout - RAM port
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  lock_timeout,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_tag_q, rd_tag_d;
  logic             lock_timeout_q, lock_timeout_d;

  logic [1:0]       rr_gnt;
  logic [1:0]       gnt_v;
  logic             gnt_id;
  logic             gnt_lock;
  logic             own_id;
  logic             own_lock;
  logic [CNT_W-1:0] cnt_inc;

  rr_arb2 u_rr_arb2 (
    .req (ram_req_vec()),
    .ptr (ptr_q),
    .gnt (rr_gnt)
  );

  function automatic logic [1:0] ram_req_vec();
    return {req1, req0};
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB;
      ptr_q          <= REQ0;
      cnt_q          <= '0;
      rd_pend_q      <= 1'b0;
      rd_tag_q       <= REQ0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      rd_pend_q      <= rd_pend_d;
      rd_tag_q       <= rd_tag_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: grant selection and RAM port mux
  // --------------------------------------------------------------------------
  always_comb begin
    gnt_v = 2'b00;
    case (state_q)
      ARB:     gnt_v = rr_gnt;
      LOCK0:   gnt_v = {1'b0, req0};
      LOCK1:   gnt_v = {req1, 1'b0};
      default: gnt_v = 2'b00;
    endcase

    gnt0     = gnt_v[0];
    gnt1     = gnt_v[1];
    ram_en   = |gnt_v;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt_v[0]) begin
      ram_we   = we0;
      ram_addr = addr0;
      ram_din  = din0;
    end else if (gnt_v[1]) begin
      ram_we   = we1;
      ram_addr = addr1;
      ram_din  = din1;
    end
  end

  assign gnt_id   = gnt_v[1];
  assign gnt_lock = gnt_id ? lock1 : lock0;
  assign own_id   = (state_q == LOCK1) ? REQ1 : REQ0;
  assign own_lock = (own_id == REQ1) ? lock1 : lock0;
  assign cnt_inc  = cnt_q + CNT_ONE;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    lock_timeout_d = 1'b0;

    case (state_q)
      ARB: begin
        if (|gnt_v) begin
          ptr_d = other_req(gnt_id);
          if (gnt_lock) begin
            state_d = lock_state_of(gnt_id);
            cnt_d   = CNT_ONE;
          end
        end
      end
      LOCK0, LOCK1: begin
        cnt_d = cnt_inc;
        if (!own_lock) begin
          // Voluntary release keeps the pointer set at lock acquisition.
          state_d = ARB;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          // Forced release: hand the next contended cycle to the other side.
          state_d        = ARB;
          cnt_d          = '0;
          lock_timeout_d = 1'b1;
          ptr_d          = other_req(own_id);
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase

    // Read-return tag: remembers which requester the RAM data belongs to.
    rd_pend_d = ram_en & ~ram_we;
    rd_tag_d  = gnt_id;
  end

  // A reset arriving while a read is in flight suppresses its return.
  assign rvalid0      = rd_pend_q & (rd_tag_q == REQ0) & ~rst;
  assign rvalid1      = rd_pend_q & (rd_tag_q == REQ1) & ~rst;
  assign rdata0       = rvalid0 ? ram_dout : '0;
  assign rdata1       = rvalid1 ? ram_dout : '0;
  assign lock_timeout = lock_timeout_q;

endmodule
`default_nettype wire
